// File: rtl/mem_arbiter_pkg.sv
// Shared types for the RAM arbiter: RAM handshake states, word type and arbiter FSM states.
package mem_arbiter_pkg;
    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_t;

    // Requesters of one class sit two indices apart, so the next in-class slot is g+2.
    function automatic int unsigned class_next(int unsigned g, int unsigned reqs);
        return (g + 2) % reqs;
    endfunction
endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side request bus plus RAM port of the arbiter, bundled as one interface.
interface mem_arbiter_if #(parameter int REQS = 4);
    import mem_arbiter_pkg::*;
    localparam int GW = $clog2(REQS);

    logic [REQS-1:0] req_ren;
    logic [REQS-1:0] req_wen;
    logic [REQS-1:0] req_lock;
    word_t [REQS-1:0] req_addr;
    word_t [REQS-1:0] req_store;
    logic [REQS-1:0] req_wait;
    logic [REQS-1:0] req_err;
    word_t           req_load;
    logic            ramREN;
    logic            ramWEN;
    word_t           ramaddr;
    word_t           ramstore;
    word_t           ramload;
    ramstate_t       ramstate;
    logic [GW-1:0]   grant_id;
    logic            busy;

    // slave: the arbiter itself; master: caches and RAM model around it.
    modport slave (
        input  req_ren, req_wen, req_lock, req_addr, req_store, ramload, ramstate,
        output req_wait, req_err, req_load, ramREN, ramWEN, ramaddr, ramstore, grant_id, busy
    );
    modport master (
        output req_ren, req_wen, req_lock, req_addr, req_store, ramload, ramstate,
        input  req_wait, req_err, req_load, ramREN, ramWEN, ramaddr, ramstore, grant_id, busy
    );
endinterface

// File: rtl/mem_arbiter_rr_pick.sv
// Round-robin picker: first masked request at or after ptr, wrapping around N slots.
module mem_arbiter_rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         mask,
    input  logic [$clog2(N)-1:0] ptr,
    output logic                 found,
    output logic [$clog2(N)-1:0] idx
);
    localparam int W = $clog2(N);

    int          j;
    logic [W-1:0] jj;

    // Scan from the farthest offset down so the nearest hit is the one that sticks.
    always_comb begin
        found = 1'b0;
        idx   = ptr;
        j     = 0;
        jj    = '0;
        for (int off = N - 1; off >= 0; off--) begin
            j = int'(ptr) + off;
            if (j >= N) j = j - N;
            jj = W'(j);
            if (req[jj] && mask[jj]) begin
                found = 1'b1;
                idx   = jj;
            end
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: dcache class over icache class, round-robin within a class,
// locked bursts, BUSY watchdog and ERROR propagation.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int CPUS    = 2,
    parameter int TIMEOUT = 64
) (
    input  logic          CLK,
    input  logic          nRST,
    mem_arbiter_if.slave  bus
);
    localparam int REQS = 2 * CPUS;
    localparam int GW   = $clog2(REQS);
    localparam int CW   = $clog2(TIMEOUT + 1);

    arb_state_t      state, state_n;
    logic [GW-1:0]   grant, dptr, iptr, dpick, ipick, winner;
    logic            dfound, ifound, cap_ren, cap_wen;
    logic [CW-1:0]   cnt;
    logic [REQS-1:0] reqv, odd_mask;
    logic            xfer, drop, fail, done;

    assign reqv = bus.req_ren | bus.req_wen;

    for (genvar g = 0; g < REQS; g++) begin : g_mask
        assign odd_mask[g] = ((g % 2) == 1);
    end

    mem_arbiter_rr_pick #(.N(REQS)) u_dpick (
        .req(reqv), .mask(odd_mask), .ptr(dptr), .found(dfound), .idx(dpick)
    );
    mem_arbiter_rr_pick #(.N(REQS)) u_ipick (
        .req(reqv), .mask(~odd_mask), .ptr(iptr), .found(ifound), .idx(ipick)
    );

    assign winner = dfound ? dpick : ipick;
    assign xfer   = (state == XFER);

    // A requester that withdrew is not listening, so abort beats any RAM answer.
    always_comb begin
        drop = xfer && !reqv[grant];
        fail = xfer && !drop &&
               ((bus.ramstate == ERROR) ||
                ((bus.ramstate != ACCESS) && (cnt == CW'(TIMEOUT - 1))));
        done = xfer && !drop && ((bus.ramstate == ACCESS) || fail);
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (dfound || ifound) state_n = XFER;
            XFER:    if (drop || fail || (done && !bus.req_lock[grant])) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state   <= IDLE;
            grant   <= '0;
            cap_ren <= 1'b0;
            cap_wen <= 1'b0;
            dptr    <= '0;
            iptr    <= '0;
            cnt     <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && (dfound || ifound)) begin
                grant   <= winner;
                cap_ren <= bus.req_ren[winner];
                cap_wen <= bus.req_wen[winner];
            end
            if (done && state_n == XFER) begin
                cap_ren <= bus.req_ren[grant];
                cap_wen <= bus.req_wen[grant];
            end
            if (done) begin
                if (grant[0]) dptr <= GW'(class_next(grant, REQS));
                else          iptr <= GW'(class_next(grant, REQS));
            end
            cnt <= (xfer && state_n == XFER && !done) ? cnt + 1'b1 : '0;
        end
    end

    always_comb begin
        bus.req_wait = '1;
        bus.req_err  = '0;
        if (done) bus.req_wait[grant] = 1'b0;
        if (fail) bus.req_err[grant]  = 1'b1;
    end

    assign bus.req_load = bus.ramload;
    assign bus.ramREN   = xfer && cap_ren;
    assign bus.ramWEN   = xfer && cap_wen;
    assign bus.ramaddr  = xfer ? bus.req_addr[grant]  : '0;
    assign bus.ramstore = xfer ? bus.req_store[grant] : '0;
    assign bus.grant_id = grant;
    assign bus.busy     = xfer;
endmodule
